updown_sweep_ctrl: RTL
======================

# updown_sweep_ctrl

Sequencer for the shared WIDTH-bit up/down counter. It generates the counter's `enable` and `upDown` controls so the count runs a triangle sweep: from 0 up to `hi_lim`, then back and forth between `hi_lim` and `lo_lim` for a programmed number of cycles. It sits beside the counter instance in the protocol timing path and gives software a start/stop/done handshake. The counter clears whenever `enable` is low, so the controller never "holds" a value: it either counts or lets the counter clear.

## Interface
- `WIDTH`, 4: counter width; must match the counter instance.
- `CYC_W`, 8: width of the sweep-cycle count.
- `clk` in 1: clock, shared with the counter.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a sweep; sampled only in IDLE.
- `stop` in 1: abort request; wins over `start` in the same cycle.
- `lo_lim` in WIDTH: lower turn point; latched on an accepted start.
- `hi_lim` in WIDTH: upper turn point; latched on an accepted start.
- `n_cyc` in CYC_W: number of full cycles; 0 means run until stopped. Latched on an accepted start.
- `count_in` in WIDTH: the counter's `count` output.
- `cnt_en` out 1: drives the counter's `enable`.
- `cnt_up` out 1: drives the counter's `upDown`.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse when a finite sweep completes.
- `cfg_err` out 1: one-cycle pulse when a start is rejected.

## Operation
- FSM states: IDLE, UP, DOWN. All outputs are registered.
- Reset values: state IDLE, `cnt_en`=0, `cnt_up`=0, `busy`=0, `done`=0, `cfg_err`=0, internal cycle counter 0.
- IDLE: `cnt_en`=0, so the counter sits at 0.
- Start acceptance (in IDLE, `start`=1, `stop`=0):
  - If `lo_lim` >= `hi_lim`: pulse `cfg_err` and stay in IDLE.
  - Otherwise: latch the limits and `n_cyc`, clear the cycle counter, and set `cnt_en`=1, `cnt_up`=1, `busy`=1. Go to UP.
- UP:
  - When `count_in` == `hi_lim`-1, the next edge sets `cnt_up`=0 and goes to DOWN.
  - The count therefore peaks at exactly `hi_lim`.
- DOWN:
  - When `count_in` == `lo_lim`+1, one cycle completes and the cycle counter increments.
  - If `n_cyc`!=0 and the incremented value == `n_cyc`: the next edge sets `cnt_en`=0, `busy`=0, pulses `done`, and goes to IDLE. The counter clears to 0 on the edge after that.
  - Otherwise the next edge sets `cnt_up`=1 and goes to UP. The count bottoms at exactly `lo_lim`.
- `stop` while busy: the next edge forces IDLE with `cnt_en`=0 and `busy`=0. No `done` pulse.
- `start` while busy: ignored.
- `n_cyc`=0: the cycle counter wraps silently and the sweep never self-terminates.
- The first ramp climbs from 0, not from `lo_lim`. `lo_lim` applies only on down-legs.

## Timing
- Let T be the edge that accepts start. The counter reads k after edge T+k.
- Example, `lo_lim`=2, `hi_lim`=5:
  - Peak 5 after edge T+5.
  - First return to 2 after edge T+8.
  - Period 2·(`hi_lim`-`lo_lim`) = 6 edges thereafter.
- `done` is high in the same cycle that `count_in`==`lo_lim` on the final cycle.
- `count_in` is 0 one cycle after `done`.
- `hi_lim`-`lo_lim`=1 is legal. The direction flips on every edge.
- `hi_lim`=2^WIDTH-1 is legal. No wrap occurs.
- Reset mid-sweep returns everything to reset values at the next edge. The counter then clears because `cnt_en` is low.

## Configuration
- `SWEEP_STAT_EN` defined: adds output `sweep_cnt` [CYC_W-1:0], the live cycle counter. It resets to 0, clears on an accepted start, and holds its final value in IDLE.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package `updown_sweep_pkg` holds:
  - the state enum `sweep_state_t` (IDLE/UP/DOWN);
  - default `WIDTH`/`CYC_W` localparams.
- No sub-module. The counter is instantiated by the integrator alongside this block. The counter's active-low reset is driven as the inverse of `reset`.

## Test plan
- Reset, then `lo_lim`=2, `hi_lim`=5, `n_cyc`=2 → `count_in` sequence 0,1,2,3,4,5,4,3,2,3,4,5,4,3,2. `done` pulses with the final 2, then the count is 0 and `busy`=0.
- `lo_lim`=5, `hi_lim`=5 start → `cfg_err` pulse, `busy` stays 0, `cnt_en` stays 0.
- `lo_lim`=0, `hi_lim`=15, `n_cyc`=0; assert `stop` after 40 cycles → no wrap past 15 or below 0, no `done`, `cnt_en`=0 the next edge, counter 0 one edge later.
- `lo_lim`=3, `hi_lim`=4, `n_cyc`=3 → alternating 4,3 after the ramp, exactly 3 lows at 3, then `done`.
- `start`=1 and `stop`=1 in the same IDLE cycle → no start. A `start` pulse while busy → limits unchanged.
- `reset` asserted mid-DOWN → all outputs 0 the next edge. A restart then behaves as from power-up.

Source files
------------

// File: rtl/updown_sweep_pkg.sv
// updown_sweep_pkg: state encoding and default widths for the triangle-sweep sequencer
package updown_sweep_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CYC_W = 8;
  typedef enum logic [1:0] {IDLE, UP, DOWN} sweep_state_t;
endpackage

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: drives enable/upDown of the shared counter for a lo/hi triangle sweep
// Optional SWEEP_STAT_EN exposes the live cycle counter as sweep_cnt.
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CYC_W = DEF_CYC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo_lim,
  input  logic [WIDTH-1:0] hi_lim,
  input  logic [CYC_W-1:0] n_cyc,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic             done,
`ifdef SWEEP_STAT_EN
  output logic [CYC_W-1:0] sweep_cnt,
`endif
  output logic             cfg_err
);
  sweep_state_t state_q, state_d;
  logic en_q, en_d, up_q, up_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [CYC_W-1:0] n_q, n_d, cyc_q, cyc_d, cyc_inc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      up_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      up_q    <= up_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      cyc_q   <= cyc_d;
    end
  end
  // Turn one count early: the counter moves on the same edge the direction changes.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    up_d    = up_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    cyc_d   = cyc_q;
    cyc_inc = cyc_q + CYC_W'(1);
    if (state_q == IDLE) begin
      if (start && !stop) begin
        if (lo_lim >= hi_lim) err_d = 1'b1;
        else begin
          state_d = UP;
          en_d    = 1'b1;
          up_d    = 1'b1;
          busy_d  = 1'b1;
          lo_d    = lo_lim;
          hi_d    = hi_lim;
          n_d     = n_cyc;
          cyc_d   = '0;
        end
      end
    end else if (stop) begin
      state_d = IDLE;
      en_d    = 1'b0;
      up_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (state_q == UP && count_in == hi_q - WIDTH'(1)) begin
      state_d = DOWN;
      up_d    = 1'b0;
    end else if (state_q == DOWN && count_in == lo_q + WIDTH'(1)) begin
      cyc_d = cyc_inc;
      if (n_q != '0 && cyc_inc == n_q) begin
        state_d = IDLE;
        en_d    = 1'b0;
        up_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = UP;
        up_d    = 1'b1;
      end
    end
  end
  assign cnt_en  = en_q;
  assign cnt_up  = up_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = err_q;
`ifdef SWEEP_STAT_EN
  assign sweep_cnt = cyc_q;
`endif
endmodule
